// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: checks the access coming out of EXE/MEM,
// issues one valid/ready request to data memory, waits for the load
// response and returns aligned, extended load data to writeback.
module mem_stage_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [OP_WIDTH-1:0]   mem_op,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic [DATA_WIDTH-1:0] dmem_req_addr,
    output logic                  dmem_req_wen,
    output logic [3:0]            dmem_req_wstrb,
    output logic [DATA_WIDTH-1:0] dmem_req_wdata,
    input  logic                  dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_resp_rdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  access_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t              state_q, state_d;
    logic [OP_WIDTH-1:0] op_p1;
    logic [1:0]          off_p1;
    logic                legal_op, misaligned, legal;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [OP_WIDTH-1:0] op,
                                                          input logic [DATA_WIDTH-1:0] word,
                                                          input logic [1:0] off);
        logic [DATA_WIDTH-1:0]        lane;
        logic signed [7:0]            lane_b;
        logic signed [15:0]           lane_h;
        logic signed [DATA_WIDTH-1:0] res;
        lane   = word >> {off, 3'b000};
        lane_b = lane[7:0];
        lane_h = lane[15:0];
        case (op)
            3'b000:  res = DATA_WIDTH'(lane_b);
            3'b001:  res = DATA_WIDTH'(lane_h);
            3'b100:  res = $signed({24'd0, lane[7:0]});
            3'b101:  res = $signed({16'd0, lane[15:0]});
            default: res = $signed(lane);
        endcase
        return res;
    endfunction

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_strb(input logic [OP_WIDTH-1:0] op,
                                              input logic [1:0] off);
        case (op[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data across lanes so any enabled lane sees the right bytes.
    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [OP_WIDTH-1:0] op,
                                                         input logic [DATA_WIDTH-1:0] wd);
        case (op[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Classify the incoming access: listed op, exclusive direction, natural alignment.
    always_comb begin
        legal_op = 1'b0;
        if (mem_ren && !mem_wen) begin
            case (mem_op)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_op = 1'b1;
                default:                                legal_op = 1'b0;
            endcase
        end else if (mem_wen && !mem_ren) begin
            case (mem_op)
                3'b000, 3'b001, 3'b010: legal_op = 1'b1;
                default:                legal_op = 1'b0;
            endcase
        end
        case (mem_op[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase
        legal = legal_op && !misaligned;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and control outputs; combinational outputs are forced low during reset.
    always_comb begin
        state_d        = state_q;
        stall          = 1'b0;
        dmem_req_valid = 1'b0;
        load_valid     = 1'b0;
        access_err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    stall   = 1'b1;
                    state_d = REQ;
                end else if (mem_ren || mem_wen) begin
                    access_err = 1'b1;
                end
            end
            REQ: begin
                stall          = 1'b1;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) state_d = dmem_req_wen ? DONE : RESP;
            end
            RESP: begin
                stall = 1'b1;
                if (dmem_resp_valid) state_d = DONE;
            end
            DONE: begin
                load_valid = !dmem_req_wen;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            stall      = 1'b0;
            access_err = 1'b0;
        end
    end

    // Latch the request payload once, when a legal access leaves IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_addr  <= '0;
            dmem_req_wen   <= 1'b0;
            dmem_req_wstrb <= 4'b0000;
            dmem_req_wdata <= '0;
            op_p1          <= '0;
            off_p1         <= 2'b00;
        end else if (state_q == IDLE && legal) begin
            dmem_req_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
            dmem_req_wen   <= mem_wen;
            dmem_req_wstrb <= mem_wen ? store_strb(mem_op, addr[1:0]) : 4'b0000;
            dmem_req_wdata <= mem_wen ? store_data(mem_op, wdata) : '0;
            op_p1          <= mem_op;
            off_p1         <= addr[1:0];
        end
    end

    // Capture the extended load result; it holds until the next load response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     load_data <= '0;
        else if (state_q == RESP && dmem_resp_valid)    load_data <= extend_load(op_p1, dmem_resp_rdata, off_p1);
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed scenarios plus randomized accesses
// checked against an arithmetic model of load/store formatting.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ren = 1'b0, mem_wen = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, dmem_req_valid, dmem_req_wen, load_valid, access_err;
    logic        dmem_req_ready = 1'b0, dmem_resp_valid = 1'b0;
    logic [31:0] dmem_req_addr, dmem_req_wdata, load_data;
    logic [31:0] dmem_resp_rdata = '0;
    logic [3:0]  dmem_req_wstrb;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;

    // Observations of the most recent access
    int          o_stall, o_lv, o_err, o_req, o_end, o_first_req;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_strb;
    logic        o_wen;
    bit          o_unstable, o_timeout;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .stall(stall), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
        .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .load_data(load_data), .load_valid(load_valid), .access_err(access_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_legal(input bit ren, input bit wen, input logic [2:0] op, input logic [31:0] a);
        if (ren == wen) return 0;
        if (ren && !(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (wen && !(op inside {3'd0, 3'd1, 3'd2})) return 0;
        return (a % size_of(op)) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] word, input logic [31:0] a);
        int     n, off;
        longint v, span;
        n    = size_of(op);
        off  = a % 4;
        span = longint'(1) << (8 * n);
        v    = (longint'(word) >> (8 * off)) % span;
        if (!op[2] && n < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] op, input logic [31:0] a);
        int s;
        s = ((1 << size_of(op)) - 1) << (a % 4);
        return s[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = size_of(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(wd >> (8 * (i % n)));
        return r;
    endfunction

    // ---------------- stimulus driver (records, does not judge) ----------------
    task automatic run_access(input bit ren, input bit wen, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int rdy_dly, input int resp_dly);
        int rdy_w, resp_w;
        bit hs, fin;
        o_stall = 0; o_lv = 0; o_err = 0; o_req = 0; o_end = -1; o_first_req = -1;
        o_unstable = 0; o_timeout = 0; o_addr = '0; o_wdata = '0; o_strb = '0; o_wen = 1'b0;
        rdy_w = 0; resp_w = 0; hs = 0; fin = 0;
        @(negedge clk);
        mem_ren = ren; mem_wen = wen; mem_op = op; addr = a; wdata = wd;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        for (int c = 0; c < 64 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (stall) o_stall++;
            if (load_valid) o_lv++;
            if (access_err) o_err++;
            if (dmem_req_valid) begin
                o_req++;
                if (o_first_req < 0) begin
                    o_first_req = cyc; o_addr = dmem_req_addr; o_wdata = dmem_req_wdata;
                    o_strb = dmem_req_wstrb; o_wen = dmem_req_wen;
                end else if (o_addr !== dmem_req_addr || o_wdata !== dmem_req_wdata ||
                             o_strb !== dmem_req_wstrb || o_wen !== dmem_req_wen) begin
                    o_unstable = 1;
                end
                // early/garbage responses while the request is pending must be ignored
                dmem_resp_valid = 1'($urandom_range(0, 1));
                dmem_resp_rdata = $urandom;
                if (rdy_w >= rdy_dly) begin dmem_req_ready = 1'b1; hs = 1; end
                else begin dmem_req_ready = 1'b0; rdy_w++; end
            end else if (!stall) begin
                fin = 1; o_end = cyc;
                mem_ren = 1'b0; mem_wen = 1'b0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
            end else if (hs) begin
                dmem_req_ready = 1'b0;
                if (resp_w >= resp_dly) begin dmem_resp_valid = 1'b1; dmem_resp_rdata = rd; end
                else begin dmem_resp_valid = 1'b0; dmem_resp_rdata = $urandom; resp_w++; end
            end
        end
        if (!fin) begin
            o_timeout = 1;
            mem_ren = 1'b0; mem_wen = 1'b0; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        mem_ren = 1'b1; mem_op = 3'b010; addr = 32'h0000_0100;
        #3;
        n_chk++; if (stall !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", stall); else n_pass++;
        n_chk++; if (dmem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%0b exp=0", dmem_req_valid); else n_pass++;
        n_chk++; if (dmem_req_addr !== 32'h0) $display("FAIL reset_req_addr got=%h exp=0", dmem_req_addr); else n_pass++;
        n_chk++; if (dmem_req_wstrb !== 4'h0 || dmem_req_wdata !== 32'h0 || dmem_req_wen !== 1'b0)
            $display("FAIL reset_payload got=%h/%h/%b exp=0/0/0", dmem_req_wstrb, dmem_req_wdata, dmem_req_wen); else n_pass++;
        n_chk++; if (load_data !== 32'h0 || load_valid !== 1'b0 || access_err !== 1'b0)
            $display("FAIL reset_load got=%h/%b/%b exp=0/0/0", load_data, load_valid, access_err); else n_pass++;
        mem_ren = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lb;
        run_access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0);
        n_chk++; if (o_timeout !== 0) $display("FAIL lb_timeout got=%0b exp=0", o_timeout); else n_pass++;
        n_chk++; if (o_stall !== 3) $display("FAIL lb_stall_cycles got=%0d exp=3", o_stall); else n_pass++;
        n_chk++; if (o_addr !== 32'h0000_1000) $display("FAIL lb_req_addr got=%h exp=00001000", o_addr); else n_pass++;
        n_chk++; if (o_strb !== 4'b0000 || o_wen !== 1'b0) $display("FAIL lb_strb_wen got=%b/%b exp=0000/0", o_strb, o_wen); else n_pass++;
        n_chk++; if (load_data !== 32'hFFFF_FF80) $display("FAIL lb_load_data got=%h exp=ffffff80", load_data); else n_pass++;
        n_chk++; if (o_lv !== 1) $display("FAIL lb_load_valid_count got=%0d exp=1", o_lv); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (load_valid !== 1'b0) $display("FAIL lb_pulse_width got=%b exp=0", load_valid); else n_pass++;
        n_chk++; if (load_data !== 32'hFFFF_FF80) $display("FAIL lb_load_hold got=%h exp=ffffff80", load_data); else n_pass++;
    endtask

    task automatic test_lh;
        run_access(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1, 2);
        n_chk++; if (load_data !== 32'h0000_BEEF) $display("FAIL lhu_load_data got=%h exp=0000beef", load_data); else n_pass++;
        n_chk++; if (o_stall !== 6) $display("FAIL lhu_stall_cycles got=%0d exp=6", o_stall); else n_pass++;
        run_access(1, 0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0);
        n_chk++; if (load_data !== 32'hFFFF_BEEF) $display("FAIL lh_load_data got=%h exp=ffffbeef", load_data); else n_pass++;
        n_chk++; if (o_lv !== 1 || o_timeout !== 0) $display("FAIL lh_valid got=%0d/%0b exp=1/0", o_lv, o_timeout); else n_pass++;
    endtask

    task automatic test_sb;
        run_access(0, 1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'h0, 3, 0);
        n_chk++; if (o_strb !== 4'b0010) $display("FAIL sb_wstrb got=%b exp=0010", o_strb); else n_pass++;
        n_chk++; if (o_wdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata got=%h exp=abababab", o_wdata); else n_pass++;
        n_chk++; if (o_addr !== 32'h0000_3000 || o_wen !== 1'b1) $display("FAIL sb_addr_wen got=%h/%b exp=00003000/1", o_addr, o_wen); else n_pass++;
        n_chk++; if (o_unstable !== 0 || o_req !== 4) $display("FAIL sb_payload_hold got=%0b/%0d exp=0/4", o_unstable, o_req); else n_pass++;
        n_chk++; if (o_stall !== 5) $display("FAIL sb_stall_cycles got=%0d exp=5", o_stall); else n_pass++;
        n_chk++; if (o_err !== 0 || o_lv !== 0) $display("FAIL sb_err_lv got=%0d/%0d exp=0/0", o_err, o_lv); else n_pass++;
    endtask

    task automatic test_illegal;
        logic [31:0] held;
        held = load_data;
        run_access(1, 0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0, 0);
        n_chk++; if (o_err !== 1 || o_req !== 0 || o_stall !== 0) $display("FAIL err_lw_misaligned got=%0d/%0d/%0d exp=1/0/0", o_err, o_req, o_stall); else n_pass++;
        run_access(0, 1, 3'b001, 32'h0000_4001, 32'h5555_5555, 32'h0, 0, 0);
        n_chk++; if (o_err !== 1 || o_req !== 0 || o_stall !== 0) $display("FAIL err_sh_misaligned got=%0d/%0d/%0d exp=1/0/0", o_err, o_req, o_stall); else n_pass++;
        run_access(1, 1, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0, 0);
        n_chk++; if (o_err !== 1 || o_req !== 0 || o_stall !== 0) $display("FAIL err_ren_wen got=%0d/%0d/%0d exp=1/0/0", o_err, o_req, o_stall); else n_pass++;
        run_access(0, 1, 3'b100, 32'h0000_4000, 32'h0, 32'h0, 0, 0);
        n_chk++; if (o_err !== 1 || o_req !== 0) $display("FAIL err_bad_store_op got=%0d/%0d exp=1/0", o_err, o_req); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (dmem_req_valid !== 1'b0 || access_err !== 1'b0 || load_data !== held)
            $display("FAIL err_after got=%b/%b/%h exp=0/0/%h", dmem_req_valid, access_err, load_data, held); else n_pass++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        mem_ren = 1'b1; mem_op = 3'b010; addr = 32'h0000_7000; dmem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        n_chk++; if (stall !== 1'b1 || dmem_req_valid !== 1'b0) $display("FAIL rstmid_in_resp got=%b/%b exp=1/0", stall, dmem_req_valid); else n_pass++;
        rst_n = 1'b0; #1;
        n_chk++; if (stall !== 1'b0 || dmem_req_valid !== 1'b0 || load_valid !== 1'b0 || access_err !== 1'b0)
            $display("FAIL rstmid_async_ctl got=%b/%b/%b/%b exp=0/0/0/0", stall, dmem_req_valid, load_valid, access_err); else n_pass++;
        n_chk++; if (load_data !== 32'h0 || dmem_req_addr !== 32'h0) $display("FAIL rstmid_async_data got=%h/%h exp=0/0", load_data, dmem_req_addr); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; mem_ren = 1'b0; dmem_req_ready = 1'b0;
        @(negedge clk);
        dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hDEAD_BEEF; #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL rstmid_idle_stall got=%b exp=0", stall); else n_pass++;
        @(negedge clk);
        dmem_resp_valid = 1'b0; #1;
        n_chk++; if (load_valid !== 1'b0 || load_data !== 32'h0 || dmem_req_valid !== 1'b0)
            $display("FAIL rstmid_late_resp got=%b/%h/%b exp=0/0/0", load_valid, load_data, dmem_req_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int e1;
        run_access(0, 1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 0, 0);
        e1 = o_end;
        n_chk++; if (o_strb !== 4'b1111 || o_wdata !== 32'hCAFE_F00D || o_addr !== 32'h0000_5004)
            $display("FAIL b2b_sw got=%b/%h/%h exp=1111/cafef00d/00005004", o_strb, o_wdata, o_addr); else n_pass++;
        n_chk++; if (o_stall !== 2) $display("FAIL b2b_sw_stall got=%0d exp=2", o_stall); else n_pass++;
        run_access(1, 0, 3'b010, 32'h0000_6008, 32'h0, 32'h1357_9BDF, 0, 0);
        n_chk++; if (o_first_req - e1 !== 2) $display("FAIL b2b_gap got=%0d exp=2", o_first_req - e1); else n_pass++;
        n_chk++; if (o_addr !== 32'h0000_6008 || o_wen !== 1'b0 || o_strb !== 4'b0000)
            $display("FAIL b2b_lw_req got=%h/%b/%b exp=00006008/0/0000", o_addr, o_wen, o_strb); else n_pass++;
        n_chk++; if (load_data !== 32'h1357_9BDF || o_lv !== 1) $display("FAIL b2b_lw_data got=%h/%0d exp=13579bdf/1", load_data, o_lv); else n_pass++;
    endtask

    task automatic test_random;
        logic [2:0]  lops[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  op;
        logic [31:0] a, wd, rd;
        bit          ren, wen, lg;
        int          k, rdy, rsp, n, exp_stall;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            a = $urandom; wd = $urandom; rd = $urandom;
            rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
            if (k < 4) begin
                ren = 1; wen = 0; op = lops[$urandom_range(0, 4)];
            end else if (k < 8) begin
                ren = 0; wen = 1; op = 3'($urandom_range(0, 2));
            end else begin
                ren = 1'($urandom); wen = 1'($urandom); op = 3'($urandom);
            end
            if (k < 8) begin
                n = size_of(op);
                a = a - (a % n);
            end
            lg = model_legal(ren, wen, op, a);
            run_access(ren, wen, op, a, wd, rd, rdy, rsp);
            if (lg) begin
                exp_stall = wen ? (2 + rdy) : (3 + rdy + rsp);
                n_chk++; if (o_timeout !== 0 || o_err !== 0) $display("FAIL rnd%0d_flow got=%0b/%0d exp=0/0", i, o_timeout, o_err); else n_pass++;
                n_chk++; if (o_stall !== exp_stall) $display("FAIL rnd%0d_stall got=%0d exp=%0d", i, o_stall, exp_stall); else n_pass++;
                n_chk++; if (o_addr !== {a[31:2], 2'b00} || o_wen !== wen || o_unstable !== 0)
                    $display("FAIL rnd%0d_req got=%h/%b/%0b exp=%h/%b/0", i, o_addr, o_wen, o_unstable, {a[31:2], 2'b00}, wen); else n_pass++;
                if (wen) begin
                    n_chk++; if (o_strb !== model_strb(op, a) || o_wdata !== model_wdata(op, wd))
                        $display("FAIL rnd%0d_store got=%b/%h exp=%b/%h", i, o_strb, o_wdata, model_strb(op, a), model_wdata(op, wd)); else n_pass++;
                    n_chk++; if (o_lv !== 0) $display("FAIL rnd%0d_store_lv got=%0d exp=0", i, o_lv); else n_pass++;
                end else begin
                    n_chk++; if (load_data !== model_load(op, rd, a))
                        $display("FAIL rnd%0d_load op=%0d a=%h got=%h exp=%h", i, op, a, load_data, model_load(op, rd, a)); else n_pass++;
                    n_chk++; if (o_lv !== 1 || o_strb !== 4'b0000) $display("FAIL rnd%0d_load_lv got=%0d/%b exp=1/0000", i, o_lv, o_strb); else n_pass++;
                end
            end else begin
                n_chk++; if (o_err !== int'(ren | wen) || o_req !== 0 || o_stall !== 0)
                    $display("FAIL rnd%0d_reject got=%0d/%0d/%0d exp=%0d/0/0", i, o_err, o_req, o_stall, int'(ren | wen)); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_lh;
        test_sb;
        test_illegal;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
